display_scan_mux: RTL and testbench



---
 rtl/display_scan_mux_pkg.sv | 21 ++
 rtl/display_scan_mux_if.sv | 30 +++
 rtl/display_scan_mux_scan_timer.sv | 55 +++++
 rtl/display_scan_mux.sv | 114 +++++++++++
 tb/tb_display_scan_mux.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_mux_pkg.sv
// Shared constants, types and helpers for the seven-segment scan driver.
// Defaults here are the values used when the display is instantiated without overrides.
package display_pkg;

    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_REFRESH_DIV  = 100000;
    localparam int DEF_BLINK_FRAMES = 64;

    typedef logic [3:0] digit_t;

    typedef enum logic {
        SCAN_IDLE,
        SCAN_RUN
    } scan_state_t;

    // Width needed to count 0..range-1, never narrower than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// Bundle between the datapath that supplies digit data and the scan driver.
// The master side supplies digits and controls; the slave side drives the display.
interface display_scan_mux_if
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIGIT_W    = $bits(digit_t)
);

    logic                          enable;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
    logic [NUM_DIGITS-1:0]         dp_in;
    logic [NUM_DIGITS-1:0]         blank_in;
    logic [NUM_DIGITS-1:0]         blink_in;
    logic [NUM_DIGITS-1:0]         digit_sel;
    logic [DIGIT_W-1:0]            digit_out;
    logic                          dp_out;
    logic                          frame_done;

    modport master (
        output enable, digits_in, dp_in, blank_in, blink_in,
        input  digit_sel, digit_out, dp_out, frame_done
    );

    modport slave (
        input  enable, digits_in, dp_in, blank_in, blink_in,
        output digit_sel, digit_out, dp_out, frame_done
    );

endinterface

// File: rtl/display_scan_mux_scan_timer.sv
// Scan timing: dwell counter per digit, digit index and frame counter for blinking.
// Strobes mark the last cycle of a frame and the last frame of a blink half-period.
module scan_timer
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    localparam int IDX_W       = cnt_width(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             advance,
    output logic [IDX_W-1:0] idx,
    output logic             frame_wrap,
    output logic             blink_wrap
);

    localparam int TICK_W  = cnt_width(REFRESH_DIV);
    localparam int FRAME_W = cnt_width(BLINK_FRAMES);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [TICK_W-1:0]  tick;
    logic [FRAME_W-1:0] frame_cnt;
    logic               tick_last;
    logic               idx_last;

    assign tick_last  = (tick == TICK_LAST);
    assign idx_last   = (idx == IDX_LAST);
    assign frame_wrap = advance && tick_last && idx_last;
    assign blink_wrap = frame_wrap && (frame_cnt == FRAME_LAST);

    // Counters only move while the scan is running; otherwise they hold so a pause resumes in place.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick      <= '0;
            idx       <= '0;
            frame_cnt <= '0;
        end else if (advance) begin
            if (tick_last) begin
                tick <= '0;
                idx  <= idx_last ? '0 : idx + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
            if (frame_wrap) begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with per-digit blank/blink and
// frame-aligned double buffering so a digit never changes part-way through a scan.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int DIGIT_W      = $bits(digit_t),
    parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic               clk,
    input  logic               reset_n,
    display_scan_mux_if.slave  bus
);

    if (NUM_DIGITS < 2 || DIGIT_W < 1 || REFRESH_DIV < 1 || BLINK_FRAMES < 1) begin : g_bad_params
        $error("display_scan_mux: illegal parameters NUM_DIGITS=%0d DIGIT_W=%0d REFRESH_DIV=%0d BLINK_FRAMES=%0d",
               NUM_DIGITS, DIGIT_W, REFRESH_DIV, BLINK_FRAMES);
    end

    localparam int IDX_W = cnt_width(NUM_DIGITS);

    scan_state_t                   state;
    scan_state_t                   state_next;
    logic                          load;
    logic                          advance;
    logic [IDX_W-1:0]              idx;
    logic                          frame_wrap;
    logic                          blink_wrap;
    logic [NUM_DIGITS*DIGIT_W-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]         shadow_dp;
    logic [NUM_DIGITS-1:0]         shadow_blank;
    logic [NUM_DIGITS-1:0]         shadow_blink;
    logic                          blink_phase;
    logic                          frame_done_q;
    logic                          off;

    assign advance = bus.enable && (state == SCAN_RUN);

    scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_scan_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .advance    (advance),
        .idx        (idx),
        .frame_wrap (frame_wrap),
        .blink_wrap (blink_wrap)
    );

    // SCAN_IDLE is the unprimed state: the first enabled edge only captures the inputs.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            SCAN_IDLE: begin
                if (bus.enable) begin
                    state_next = SCAN_RUN;
                    load       = 1'b1;
                end
            end
            SCAN_RUN: load = frame_wrap;
            default:  state_next = SCAN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SCAN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_blank  <= '0;
            shadow_blink  <= '0;
            blink_phase   <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            if (load) begin
                shadow_digits <= bus.digits_in;
                shadow_dp     <= bus.dp_in;
                shadow_blank  <= bus.blank_in;
                shadow_blink  <= bus.blink_in;
            end
            if (blink_wrap) begin
                blink_phase <= ~blink_phase;
            end
            frame_done_q <= frame_wrap;
        end
    end

    // A dark slot still occupies its dwell time, so the lit digits keep their duty cycle.
    always_comb begin
        bus.digit_sel = '0;
        bus.digit_out = '0;
        bus.dp_out    = 1'b0;
        off = shadow_blank[idx] | (shadow_blink[idx] & blink_phase);
        if (state == SCAN_RUN && bus.enable && !off) begin
            bus.digit_sel = NUM_DIGITS'(1) << idx;
            bus.digit_out = shadow_digits[idx*DIGIT_W +: DIGIT_W];
            bus.dp_out    = shadow_dp[idx];
        end
    end

    assign bus.frame_done = frame_done_q & bus.enable;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: each scenario queues per-cycle stimulus with
// the outputs expected after that cycle's clock edge, then replays and compares.
module tb_display_scan_mux;
    import display_pkg::*;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int RD = 4;
    localparam int BF = 2;

    typedef struct packed {
        logic        rst_n;
        logic        en;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
    } stim_t;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] code;
        logic       dp;
        logic       fd;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset_n;
    stim_t cur;
    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    display_scan_mux_if #(.NUM_DIGITS(ND), .DIGIT_W(DW)) bus ();

    display_scan_mux #(
        .NUM_DIGITS   (ND),
        .DIGIT_W      (DW),
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic push_expect(input exp_t e);
        stim_q.push_back(cur);
        exp_q.push_back(e);
    endtask

    task automatic push_dark(input int n);
        exp_t e;
        e = '0;
        for (int k = 0; k < n; k++) push_expect(e);
    endtask

    task automatic push_slot(input int i, input logic fd_first, input logic [3:0] code,
                             input logic dp, input logic vis, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.sel  = vis ? 4'(1 << i) : 4'b0000;
            e.code = vis ? code : 4'h0;
            e.dp   = vis ? dp : 1'b0;
            e.fd   = (k == 0) ? fd_first : 1'b0;
            push_expect(e);
        end
    endtask

    task automatic push_frame(input logic fd_first, input logic [15:0] d,
                              input logic [3:0] dp, input logic [3:0] off);
        for (int i = 0; i < ND; i++) begin
            push_slot(i, (i == 0) ? fd_first : 1'b0, d[i*4 +: 4], dp[i], !off[i], RD);
        end
    endtask

    task automatic start_with_reset();
        cur = '0;
        push_dark(2);
        cur.rst_n = 1'b1;
    endtask

    // Drives one queued stimulus, lets one edge pass and samples on the falling edge.
    task automatic apply_and_sample(output exp_t obs, output exp_t want);
        stim_t s;
        s    = stim_q.pop_front();
        want = exp_q.pop_front();
        reset_n       = s.rst_n;
        bus.enable    = s.en;
        bus.digits_in = s.digits;
        bus.dp_in     = s.dp;
        bus.blank_in  = s.blank;
        bus.blink_in  = s.blink;
        @(negedge clk);
        obs.sel  = bus.digit_sel;
        obs.code = bus.digit_out;
        obs.dp   = bus.dp_out;
        obs.fd   = bus.frame_done;
    endtask

    task automatic test_reset();
        exp_t o, e;
        cur = '0;
        cur.digits = 16'h4321;
        push_dark(2);
        cur.en = 1'b1;
        push_dark(2);
        while (stim_q.size() > 0) begin
            apply_and_sample(o, e);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL reset vec %0d: got sel=%b code=%h dp=%b fd=%b, want sel=%b code=%h dp=%b fd=%b",
                         vectors, o.sel, o.code, o.dp, o.fd, e.sel, e.code, e.dp, e.fd);
            end
        end
    endtask

    task automatic test_scan();
        exp_t o, e;
        start_with_reset();
        cur.en     = 1'b1;
        cur.digits = 16'h4321;
        push_frame(1'b0, 16'h4321, 4'b0000, 4'b0000);
        push_frame(1'b1, 16'h4321, 4'b0000, 4'b0000);
        push_slot(0, 1'b1, 4'h1, 1'b0, 1'b1, 1);
        while (stim_q.size() > 0) begin
            apply_and_sample(o, e);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL scan vec %0d: got sel=%b code=%h dp=%b fd=%b, want sel=%b code=%h dp=%b fd=%b",
                         vectors, o.sel, o.code, o.dp, o.fd, e.sel, e.code, e.dp, e.fd);
            end
        end
    endtask

    task automatic test_double_buffer();
        exp_t o, e;
        start_with_reset();
        cur.en     = 1'b1;
        cur.digits = 16'h4321;
        push_slot(0, 1'b0, 4'h1, 1'b0, 1'b1, RD);
        push_slot(1, 1'b0, 4'h2, 1'b0, 1'b1, 2);
        cur.digits = 16'h9876;
        push_slot(1, 1'b0, 4'h2, 1'b0, 1'b1, RD - 2);
        push_slot(2, 1'b0, 4'h3, 1'b0, 1'b1, RD);
        push_slot(3, 1'b0, 4'h4, 1'b0, 1'b1, RD);
        push_frame(1'b1, 16'h9876, 4'b0000, 4'b0000);
        while (stim_q.size() > 0) begin
            apply_and_sample(o, e);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL double_buffer vec %0d: got sel=%b code=%h dp=%b fd=%b, want sel=%b code=%h dp=%b fd=%b",
                         vectors, o.sel, o.code, o.dp, o.fd, e.sel, e.code, e.dp, e.fd);
            end
        end
    endtask

    task automatic test_blank_dp();
        exp_t o, e;
        start_with_reset();
        cur.en     = 1'b1;
        cur.digits = 16'h4321;
        cur.blank  = 4'b0100;
        cur.dp     = 4'b0001;
        push_frame(1'b0, 16'h4321, 4'b0001, 4'b0100);
        push_frame(1'b1, 16'h4321, 4'b0001, 4'b0100);
        while (stim_q.size() > 0) begin
            apply_and_sample(o, e);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL blank_dp vec %0d: got sel=%b code=%h dp=%b fd=%b, want sel=%b code=%h dp=%b fd=%b",
                         vectors, o.sel, o.code, o.dp, o.fd, e.sel, e.code, e.dp, e.fd);
            end
        end
    endtask

    task automatic test_blink();
        exp_t o, e;
        start_with_reset();
        cur.en     = 1'b1;
        cur.digits = 16'h4321;
        cur.blink  = 4'b1000;
        for (int f = 0; f < 6; f++) begin
            push_frame(f > 0, 16'h4321, 4'b0000, (f == 2 || f == 3) ? 4'b1000 : 4'b0000);
        end
        while (stim_q.size() > 0) begin
            apply_and_sample(o, e);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL blink vec %0d: got sel=%b code=%h dp=%b fd=%b, want sel=%b code=%h dp=%b fd=%b",
                         vectors, o.sel, o.code, o.dp, o.fd, e.sel, e.code, e.dp, e.fd);
            end
        end
    endtask

    task automatic test_enable_pause();
        exp_t o, e;
        start_with_reset();
        cur.en     = 1'b1;
        cur.digits = 16'h4321;
        push_slot(0, 1'b0, 4'h1, 1'b0, 1'b1, RD);
        push_slot(1, 1'b0, 4'h2, 1'b0, 1'b1, 3);
        cur.en = 1'b0;
        push_dark(10);
        cur.en = 1'b1;
        push_slot(1, 1'b0, 4'h2, 1'b0, 1'b1, 1);
        push_slot(2, 1'b0, 4'h3, 1'b0, 1'b1, RD);
        push_slot(3, 1'b0, 4'h4, 1'b0, 1'b1, RD);
        push_slot(0, 1'b1, 4'h1, 1'b0, 1'b1, 2);
        while (stim_q.size() > 0) begin
            apply_and_sample(o, e);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL enable_pause vec %0d: got sel=%b code=%h dp=%b fd=%b, want sel=%b code=%h dp=%b fd=%b",
                         vectors, o.sel, o.code, o.dp, o.fd, e.sel, e.code, e.dp, e.fd);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t o, e;
        start_with_reset();
        cur.en     = 1'b1;
        cur.digits = 16'h4321;
        push_slot(0, 1'b0, 4'h1, 1'b0, 1'b1, RD);
        push_slot(1, 1'b0, 4'h2, 1'b0, 1'b1, 2);
        cur.rst_n  = 1'b0;
        cur.digits = 16'hBCDA;
        cur.dp     = 4'b0010;
        push_dark(1);
        cur.rst_n = 1'b1;
        push_frame(1'b0, 16'hBCDA, 4'b0010, 4'b0000);
        push_slot(0, 1'b1, 4'hA, 1'b0, 1'b1, 1);
        while (stim_q.size() > 0) begin
            apply_and_sample(o, e);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_frame vec %0d: got sel=%b code=%h dp=%b fd=%b, want sel=%b code=%h dp=%b fd=%b",
                         vectors, o.sel, o.code, o.dp, o.fd, e.sel, e.code, e.dp, e.fd);
            end
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.enable    = 1'b0;
        bus.digits_in = '0;
        bus.dp_in     = '0;
        bus.blank_in  = '0;
        bus.blink_in  = '0;
        test_reset();
        test_scan();
        test_double_buffer();
        test_blank_dp();
        test_blink();
        test_enable_pause();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
